// File: rtl/lifo_arb_if.sv
// Client-side and lifo-side signal bundle for lifo_arb; the arbiter takes the
// slave modport, the client/lifo environment drives the master modport.
interface lifo_arb_if #(
    parameter int DWIDTH = 8,
    parameter int NCLI   = 4
);
    logic [NCLI-1:0]        push_req_i;
    logic [NCLI*DWIDTH-1:0] push_data_i;
    logic [NCLI-1:0]        push_ack_o;
    logic [NCLI-1:0]        pop_req_i;
    logic [NCLI-1:0]        pop_ack_o;
    logic [NCLI-1:0]        rd_valid_o;
    logic [DWIDTH-1:0]      rd_data_o;
    logic                   lifo_wrreq_o;
    logic                   lifo_rdreq_o;
    logic [DWIDTH-1:0]      lifo_data_o;
    logic [DWIDTH-1:0]      lifo_q_i;
    logic                   lifo_empty_i;
    logic                   lifo_full_i;

    modport slave (
        input  push_req_i, push_data_i, pop_req_i,
        input  lifo_q_i, lifo_empty_i, lifo_full_i,
        output push_ack_o, pop_ack_o, rd_valid_o, rd_data_o,
        output lifo_wrreq_o, lifo_rdreq_o, lifo_data_o
    );

    modport master (
        output push_req_i, push_data_i, pop_req_i,
        output lifo_q_i, lifo_empty_i, lifo_full_i,
        input  push_ack_o, pop_ack_o, rd_valid_o, rd_data_o,
        input  lifo_wrreq_o, lifo_rdreq_o, lifo_data_o
    );
endinterface

// File: rtl/lifo_arb.sv
// Round-robin arbiter giving NCLI clients push/pop access to one shared lifo.
// Optional per-client statistics counters are enabled by LIFO_ARB_STATS_EN.
module lifo_arb #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int NCLI   = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    lifo_arb_if.slave bus
`ifdef LIFO_ARB_STATS_EN
    ,
    output logic [NCLI*16-1:0] push_cnt_o,
    output logic [NCLI*16-1:0] pop_cnt_o,
    output logic [NCLI*16-1:0] stall_cnt_o
`endif
);
    localparam int PW = $clog2(NCLI);

    if (NCLI < 2 || NCLI > 8 || AWIDTH < 1) begin : g_bad_cfg
        $error("lifo_arb: NCLI must be 2..8 and AWIDTH at least 1");
    end

    logic [NCLI-1:0] pop_elig;
    logic [NCLI-1:0] push_elig;
    logic [NCLI-1:0] elig;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   grant_idx;
    logic            grant_found;
    logic [NCLI-1:0] push_ack;
    logic [NCLI-1:0] pop_ack;
    logic [NCLI-1:0] rd_valid_q;

    assign pop_elig  = bus.pop_req_i  & {NCLI{~bus.lifo_empty_i}};
    assign push_elig = bus.push_req_i & {NCLI{~bus.lifo_full_i}};
    assign elig      = pop_elig | push_elig;

    // First eligible client at or above rr_ptr, wrapping modulo NCLI.
    always_comb begin : p_scan
        int idx;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NCLI; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NCLI) idx = idx - NCLI;
            if (!grant_found && elig[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PW'(idx);
            end
        end
    end

    // The granted client's pop beats its push; reset masks every request/ack.
    always_comb begin : p_grant
        push_ack         = '0;
        pop_ack          = '0;
        bus.lifo_wrreq_o = 1'b0;
        bus.lifo_rdreq_o = 1'b0;
        bus.lifo_data_o  = '0;
        if (grant_found && rst_n_i) begin
            if (pop_elig[grant_idx]) begin
                pop_ack[grant_idx] = 1'b1;
                bus.lifo_rdreq_o   = 1'b1;
            end else begin
                push_ack[grant_idx] = 1'b1;
                bus.lifo_wrreq_o    = 1'b1;
                bus.lifo_data_o     = bus.push_data_i[int'(grant_idx)*DWIDTH +: DWIDTH];
            end
        end
    end

    assign bus.push_ack_o = push_ack;
    assign bus.pop_ack_o  = pop_ack;

    // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rr_ptr     <= '0;
            rd_valid_q <= '0;
        end else begin
            if (grant_found) begin
                rr_ptr <= (int'(grant_idx) == NCLI - 1) ? '0 : grant_idx + PW'(1);
            end
            rd_valid_q <= pop_ack;
        end
    end

    assign bus.rd_valid_o = rd_valid_q;
    assign bus.rd_data_o  = (|rd_valid_q) ? bus.lifo_q_i : '0;

`ifdef LIFO_ARB_STATS_EN
    for (genvar k = 0; k < NCLI; k++) begin : g_stats
        logic [15:0] push_cnt;
        logic [15:0] pop_cnt;
        logic [15:0] stall_cnt;
        logic        stalled;

        // A held request that got no ack this cycle counts as a stall.
        assign stalled = (bus.push_req_i[k] | bus.pop_req_i[k]) & ~(push_ack[k] | pop_ack[k]);

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                push_cnt  <= '0;
                pop_cnt   <= '0;
                stall_cnt <= '0;
            end else begin
                if (push_ack[k] && push_cnt != 16'hFFFF)   push_cnt  <= push_cnt + 16'd1;
                if (pop_ack[k] && pop_cnt != 16'hFFFF)     pop_cnt   <= pop_cnt + 16'd1;
                if (stalled && stall_cnt != 16'hFFFF)      stall_cnt <= stall_cnt + 16'd1;
            end
        end

        assign push_cnt_o[k*16 +: 16]  = push_cnt;
        assign pop_cnt_o[k*16 +: 16]   = pop_cnt;
        assign stall_cnt_o[k*16 +: 16] = stall_cnt;
    end
`endif
endmodule
